key_event_gen: RTL and testbench
================================

Name: key_event_gen

Overview:
- Consumes the synchronized, active-high key level produced by the 2-flop input synchronizer.
- Turns that level into clean game events:
  - one-cycle press pulse after debounce,
  - auto-repeat press pulses while the key is held,
  - one-cycle release pulse after debounced release,
  - a held level.
- One instance per player button, feeding the frog movement logic.

Parameters:
- DEBOUNCE_CYCLES, 4: consecutive identical samples required to accept a press or a release (≥1).
- HOLD_CYCLES, 16: cycles from the initial press pulse to the first repeat pulse (≥2).
- REPEAT_CYCLES, 8: cycles between successive repeat pulses (≥2).
- CNT_W, 16: counter width. Must represent max(DEBOUNCE_CYCLES, HOLD_CYCLES, REPEAT_CYCLES).

Ports:
- clk, input, 1: system clock. Only clock.
- reset, input, 1: synchronous, active-high reset.
- key_sync, input, 1: synchronized key level, 1 = pressed. Already metastability-safe; no further synchronization inside.
- repeat_en, input, 1: 1 enables auto-repeat.
- press, output, 1: registered; one-cycle pulse per accepted press and per repeat.
- release, output, 1: registered; one-cycle pulse per accepted release.
- held, output, 1: registered; 1 while the key is debounced-pressed.

Behaviour:
- Reset and general rules:
  - Reset is synchronous, active-high, sampled on posedge clk.
  - Reset forces state IDLE, all counters 0, and press=release=held=0. These values are visible after the reset edge.
  - Reset overrides all other inputs.
  - All outputs are registered. press and release are never high in the same cycle.
- States: IDLE, DEB_PRESS, HELD_WAIT, HELD_REPEAT, DEB_RELEASE.
- IDLE:
  - key_sync=1 → DEB_PRESS with debounce count=1.
  - key_sync=0 → stay.
- DEB_PRESS:
  - Each edge with key_sync=1 increments the count.
  - On the DEBOUNCE_CYCLES-th consecutive 1 sample → HELD_WAIT, press=1 for one cycle, held=1, repeat timer cleared.
  - Any 0 sample → IDLE, no pulse.
  - Latency: key_sync first sampled 1 at edge k gives press/held visible after edge k+DEBOUNCE_CYCLES-1.
  - DEBOUNCE_CYCLES=1: press appears after edge k.
- HELD_WAIT:
  - repeat_en=1: repeat timer increments each cycle. When it reaches HOLD_CYCLES, press=1 for one cycle, timer cleared, → HELD_REPEAT.
  - Result: first repeat pulse comes exactly HOLD_CYCLES cycles after the initial press pulse.
  - repeat_en=0: timer held at 0, no pulses.
- HELD_REPEAT:
  - Timer increments each cycle. At REPEAT_CYCLES: press=1 for one cycle, timer cleared.
  - Pulse spacing is exactly REPEAT_CYCLES.
  - repeat_en=0 → HELD_WAIT with timer cleared. Re-enabling restarts the full HOLD_CYCLES delay.
- Release detection (HELD_WAIT or HELD_REPEAT):
  - key_sync=0 sample → DEB_RELEASE with count=1. The originating state is remembered.
  - Repeat timer is frozen; held stays 1.
- DEB_RELEASE:
  - No press pulses are emitted.
  - On the DEBOUNCE_CYCLES-th consecutive 0 sample → IDLE, release=1 for one cycle, held=0 in that same cycle.
  - Any 1 sample → back to the originating held state; repeat timer resumes from its frozen value.
  - A repeat due during DEB_RELEASE is not emitted and not queued.
- Simultaneous events:
  - If the repeat timer expires on the same edge key_sync first reads 0, the release path wins: no press pulse.
- Reset mid-operation (any state):
  - Immediate return to IDLE with outputs 0; no release pulse.
  - A key still held after reset must pass a full debounce before press.
- Counters saturate at their terminal value; they never wrap.

Test Plan:
- Clean press/release (defaults): reset 2 cycles; key_sync=1 from edge 0 → press=1 only in the cycle after edge 3, held=1 from that cycle. Set key_sync=0 at edge 20 → release=1 in the cycle after edge 23, held=0 there. Total press count 1.
- Bounce rejection: key_sync=1 for 3 cycles, then 0 → press never asserts, held stays 0. Same for a 1-0-1-0 pattern.
- Auto-repeat: repeat_en=1, hold key 60 cycles past the initial press at cycle P → press pulses at P, P+16, P+24, P+32, P+40, P+48, P+56; no other press cycles.
- Repeat disabled: repeat_en=0, hold 60 cycles → exactly one press pulse, held=1 throughout. Raise repeat_en at cycle P+30 → next pulse at P+46.
- Release bounce: while held, key_sync=0 for 2 cycles, then 1 → no release pulse, held stays 1, no press during the zeros. Repeat schedule is shifted by exactly 2 cycles.
- Reset mid-hold: assert reset while held with key_sync=1 → outputs 0 after the reset edge, no release pulse. Deassert with key still 1 → press 4 samples after the first post-reset sample.

Source files
------------

// File: rtl/key_event_gen.sv
// Debounced key event generator: press pulse (plus auto-repeat), release pulse
// and held level from one synchronized key input. One instance per button.
//
// state       | meaning
// ------------+-------------------------------------------------------------
// IDLE        | key released and stable, waiting for a 1 sample
// DEB_PRESS   | counting consecutive 1 samples toward an accepted press
// HELD_WAIT   | pressed; waiting out the initial hold delay (or repeat off)
// HELD_REPEAT | pressed; emitting repeat pulses every REPEAT_CYCLES
// DEB_RELEASE | pressed; counting consecutive 0 samples toward a release
module key_event_gen #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int HOLD_CYCLES     = 16,
  parameter int REPEAT_CYCLES   = 8,
  parameter int CNT_W           = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic key_sync,
  input  logic repeat_en,
  output logic press,
  output logic release_pulse,
  output logic held
);

  typedef enum logic [2:0] {
    IDLE        = 3'd0,
    DEB_PRESS   = 3'd1,
    HELD_WAIT   = 3'd2,
    HELD_REPEAT = 3'd3,
    DEB_RELEASE = 3'd4
  } state_t;

  localparam logic             DEB_ONE = (DEBOUNCE_CYCLES == 1);
  localparam logic [CNT_W-1:0] DEB_LD  = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] HOLD_LD = CNT_W'(HOLD_CYCLES);
  localparam logic [CNT_W-1:0] RPT_LD  = CNT_W'(REPEAT_CYCLES);
  localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);
  localparam logic [CNT_W-1:0] ZERO    = '0;

  state_t           state, state_nxt, held_base;
  logic [CNT_W-1:0] deb_cnt, deb_nxt;
  logic [CNT_W-1:0] rpt_cnt, rpt_nxt;
  logic             org_rpt, org_nxt;
  logic             held_step, rpt_fire;
  logic             press_nxt, release_nxt, held_nxt;

  // Both timers are down-counters holding "samples/cycles still to go";
  // terminal count is 1, and they bottom out at 0 rather than wrapping.
  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      deb_cnt       <= ZERO;
      rpt_cnt       <= ZERO;
      org_rpt       <= 1'b0;
      press         <= 1'b0;
      release_pulse <= 1'b0;
      held          <= 1'b0;
    end else begin
      state         <= state_nxt;
      deb_cnt       <= deb_nxt;
      rpt_cnt       <= rpt_nxt;
      org_rpt       <= org_nxt;
      press         <= press_nxt;
      release_pulse <= release_nxt;
      held          <= held_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    deb_nxt   = deb_cnt;
    rpt_nxt   = rpt_cnt;
    org_nxt   = org_rpt;
    held_step = 1'b0;
    rpt_fire  = 1'b0;
    held_base = (state == DEB_RELEASE) ? (org_rpt ? HELD_REPEAT : HELD_WAIT) : state;

    case (state)
      IDLE: begin
        if (key_sync) begin
          if (DEB_ONE) begin
            state_nxt = HELD_WAIT;
            deb_nxt   = ZERO;
            rpt_nxt   = HOLD_LD;
          end else begin
            state_nxt = DEB_PRESS;
            deb_nxt   = DEB_LD;
          end
        end
      end
      DEB_PRESS: begin
        if (!key_sync) begin
          state_nxt = IDLE;
          deb_nxt   = ZERO;
        end else if (deb_cnt <= ONE) begin
          state_nxt = HELD_WAIT;
          deb_nxt   = ZERO;
          rpt_nxt   = HOLD_LD;
        end else begin
          deb_nxt = deb_cnt - ONE;
        end
      end
      HELD_WAIT, HELD_REPEAT: begin
        if (!key_sync) begin
          if (DEB_ONE) begin
            state_nxt = IDLE;
            deb_nxt   = ZERO;
            rpt_nxt   = ZERO;
          end else begin
            state_nxt = DEB_RELEASE;
            deb_nxt   = DEB_LD;
            org_nxt   = (state == HELD_REPEAT);
          end
        end else begin
          held_step = 1'b1;
        end
      end
      DEB_RELEASE: begin
        if (key_sync) begin
          // bounce back: this edge counts as a normal held-state cycle
          held_step = 1'b1;
          deb_nxt   = ZERO;
        end else if (deb_cnt <= ONE) begin
          state_nxt = IDLE;
          deb_nxt   = ZERO;
          rpt_nxt   = ZERO;
        end else begin
          deb_nxt = deb_cnt - ONE;
        end
      end
      default: begin
        state_nxt = IDLE;
        deb_nxt   = ZERO;
        rpt_nxt   = ZERO;
      end
    endcase

    if (held_step) begin
      if (!repeat_en) begin
        state_nxt = HELD_WAIT;
        rpt_nxt   = HOLD_LD;
      end else if (rpt_cnt <= ONE) begin
        rpt_fire  = 1'b1;
        state_nxt = HELD_REPEAT;
        rpt_nxt   = RPT_LD;
      end else begin
        state_nxt = held_base;
        rpt_nxt   = rpt_cnt - ONE;
      end
    end
  end

  always_comb begin
    press_nxt   = rpt_fire ||
                  ((state_nxt == HELD_WAIT) && ((state == IDLE) || (state == DEB_PRESS)));
    release_nxt = (state_nxt == IDLE) &&
                  ((state == HELD_WAIT) || (state == HELD_REPEAT) || (state == DEB_RELEASE));
    held_nxt    = (state_nxt == HELD_WAIT) || (state_nxt == HELD_REPEAT) ||
                  (state_nxt == DEB_RELEASE);
  end

endmodule

// File: tb/tb_key_event_gen.sv
// Directed bench for key_event_gen: run-length / elapsed-time model checked
// every cycle, plus literal event-edge expectations per scenario.
module tb_key_event_gen;

  localparam int D = 4;
  localparam int H = 16;
  localparam int R = 8;

  logic clk = 1'b0;
  logic reset;
  logic key_sync;
  logic repeat_en;
  logic press;
  logic release_pulse;
  logic held;

  key_event_gen #(
    .DEBOUNCE_CYCLES(D),
    .HOLD_CYCLES    (H),
    .REPEAT_CYCLES  (R),
    .CNT_W          (16)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .key_sync     (key_sync),
    .repeat_en    (repeat_en),
    .press        (press),
    .release_pulse(release_pulse),
    .held         (held)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  // model: debounced level flips when a run of the opposite level reaches D;
  // repeats fire when held-time t hits H, H+R, H+2R, ...
  bit m_deb, m_lvl, m_press, m_rel;
  int m_run, m_t;
  int m_press_q[$];

  int press_q[$];
  int rel_q[$];
  int held_cnt;
  int e0, p;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s at edge %0d: got %0d, expected %0d", name, cyc, act, exp);
    end
  endtask

  task automatic model_step(input logic k, input logic e, input logic r);
    m_press = 1'b0;
    m_rel   = 1'b0;
    if (r) begin
      m_deb = 1'b0; m_run = 0; m_lvl = 1'b0; m_t = 0;
    end else begin
      if (m_run > 0 && k == m_lvl) m_run++;
      else m_run = 1;
      m_lvl = k;
      if (!m_deb) begin
        if (k && m_run == D) begin m_deb = 1'b1; m_press = 1'b1; m_t = 0; end
      end else if (!k) begin
        if (m_run == D) begin m_deb = 1'b0; m_rel = 1'b1; end
      end else if (!e) begin
        m_t = 0;
      end else begin
        m_t++;
        if (m_t >= H && ((m_t - H) % R) == 0) m_press = 1'b1;
      end
    end
    if (m_press) m_press_q.push_back(cyc);
  endtask

  task automatic compare_now();
    chk("press", int'(press), int'(m_press));
    chk("release", int'(release_pulse), int'(m_rel));
    chk("held", int'(held), int'(m_deb));
    if (press) press_q.push_back(cyc);
    if (release_pulse) rel_q.push_back(cyc);
    if (held) held_cnt++;
  endtask

  task automatic tick(input logic k, input logic e, input logic r);
    key_sync  = k;
    repeat_en = e;
    reset     = r;
    @(posedge clk);
    cyc++;
    model_step(k, e, r);
    @(negedge clk);
    compare_now();
  endtask

  task automatic hold(input logic k, input logic e, input int n);
    repeat (n) tick(k, e, 1'b0);
  endtask

  task automatic start_test();
    hold(1'b0, 1'b0, 6);
    press_q.delete();
    rel_q.delete();
    m_press_q.delete();
    held_cnt = 0;
    e0 = cyc + 1;
    p  = e0 + D - 1;
  endtask

  initial begin
    reset = 1'b1; key_sync = 1'b0; repeat_en = 1'b0;
    @(negedge clk);
    tick(1'b0, 1'b0, 1'b1);
    tick(1'b0, 1'b0, 1'b1);
    chk("reset_press", int'(press), 0);
    chk("reset_release", int'(release_pulse), 0);
    chk("reset_held", int'(held), 0);

    // clean press, key dropped at edge e0+20
    start_test();
    hold(1'b1, 1'b0, 20);
    hold(1'b0, 1'b0, 8);
    chk("clean_press_count", press_q.size(), 1);
    if (press_q.size() > 0) chk("clean_press_edge", press_q[0] - e0, 3);
    chk("clean_rel_count", rel_q.size(), 1);
    if (rel_q.size() > 0) chk("clean_rel_edge", rel_q[0] - e0, 23);
    chk("clean_held_cycles", held_cnt, 20);

    // bounce rejection
    start_test();
    hold(1'b1, 1'b0, 3);
    tick(1'b0, 1'b0, 1'b0);
    tick(1'b1, 1'b0, 1'b0);
    tick(1'b0, 1'b0, 1'b0);
    tick(1'b1, 1'b0, 1'b0);
    hold(1'b0, 1'b0, 4);
    chk("bounce_press_count", press_q.size(), 0);
    chk("bounce_held_cycles", held_cnt, 0);

    // auto-repeat over 60 cycles of hold
    start_test();
    hold(1'b1, 1'b1, 64);
    hold(1'b0, 1'b1, 6);
    chk("rep_count", press_q.size(), 7);
    chk("rep_model_count", m_press_q.size(), 7);
    for (int i = 0; i < 7 && i < press_q.size(); i++)
      chk($sformatf("rep_edge%0d", i), press_q[i] - p, (i == 0) ? 0 : 8 + 8 * i);
    chk("rep_rel_count", rel_q.size(), 1);

    // repeat disabled, 60 cycles
    start_test();
    hold(1'b1, 1'b0, 64);
    hold(1'b0, 1'b0, 6);
    chk("norep_count", press_q.size(), 1);
    chk("norep_held_cycles", held_cnt, 64);

    // repeat enabled from edge p+31
    start_test();
    hold(1'b1, 1'b0, 34);
    hold(1'b1, 1'b1, 20);
    hold(1'b0, 1'b1, 6);
    chk("reen_count", press_q.size(), 2);
    if (press_q.size() > 1) chk("reen_edge", press_q[1] - p, 46);

    // release bounce: two zero samples at p+18, p+19
    start_test();
    hold(1'b1, 1'b1, 21);
    hold(1'b0, 1'b1, 2);
    hold(1'b1, 1'b1, 21);
    hold(1'b0, 1'b1, 6);
    chk("rb_count", press_q.size(), 4);
    if (press_q.size() > 3) begin
      chk("rb_edge1", press_q[1] - p, 16);
      chk("rb_edge2", press_q[2] - p, 26);
      chk("rb_edge3", press_q[3] - p, 34);
    end
    chk("rb_rel_count", rel_q.size(), 1);
    if (rel_q.size() > 0) chk("rb_rel_edge", rel_q[0] - p, 44);

    // repeat due on the same edge as the first zero sample
    start_test();
    hold(1'b1, 1'b1, 19);
    tick(1'b0, 1'b1, 1'b0);
    hold(1'b1, 1'b1, 4);
    hold(1'b0, 1'b1, 6);
    chk("sim_count", press_q.size(), 2);
    if (press_q.size() > 1) chk("sim_edge", press_q[1] - p, 17);

    // reset mid-hold with key still pressed
    start_test();
    hold(1'b1, 1'b1, 8);
    tick(1'b1, 1'b1, 1'b1);
    chk("rst_mid_press", int'(press), 0);
    chk("rst_mid_held", int'(held), 0);
    chk("rst_mid_release", int'(release_pulse), 0);
    hold(1'b1, 1'b1, 7);
    hold(1'b0, 1'b1, 6);
    chk("rst_press_count", press_q.size(), 2);
    if (press_q.size() > 1) chk("rst_press_edge", press_q[1] - p, 9);
    chk("rst_rel_count", rel_q.size(), 1);
    if (rel_q.size() > 0) chk("rst_rel_edge", rel_q[0] - p, 16);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
